bcd_time_field_counter: RTL and testbench
=========================================

Name: bcd_time_field_counter

Overview:
- Parametrised two-digit BCD counter for one clock time field: seconds or minutes (00–59), hours-24 (00–23), or hours-12 (01–12).
- Successor to the fixed 3-bit minutes-tens counter. Adds:
  - a configurable range;
  - up/down counting;
  - synchronous preset load for time setting;
  - a registered carry/borrow pulse for chaining fields.
- Instances are cascaded: the `carry` output of one field drives the `tick` input of the next.

Parameters:
- MIN_VAL, 0, lowest value of the field (decimal, 0..98).
- MAX_VAL, 59, highest value of the field (decimal, MIN_VAL+1..99).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- tick  input  1  count request; one step per cycle in which it is high.
- pause  input  1  1 = hold the value; tick is ignored.
- dir  input  1  0 = count up, 1 = count down.
- load  input  1  synchronous preset strobe.
- load_tens  input  4  BCD tens digit to preset.
- load_ones  input  4  BCD ones digit to preset.
- tens  output  4  current tens digit (BCD).
- ones  output  4  current ones digit (BCD).
- carry  output  1  one-cycle pulse: wrap up (MAX→MIN) or borrow (MIN→MAX).
- load_err  output  1  one-cycle pulse: a rejected load.

Behaviour:
- Reset (reset = 0, asynchronous):
  - {tens, ones} = BCD(MIN_VAL);
  - carry = 0, load_err = 0;
  - held until reset deasserts.
  - Reset mid-count or mid-load discards the operation; no carry is issued.
- Priority each rising edge: load > pause > tick.
- Load with a valid value (both digits ≤ 9 and MIN_VAL ≤ 10·tens + ones ≤ MAX_VAL):
  - value takes the loaded digits next cycle;
  - carry = 0.
- Load with an invalid value:
  - value unchanged;
  - load_err = 1 for exactly one cycle;
  - carry = 0.
- Load is accepted regardless of pause. A tick in the same cycle as a load is dropped.
- pause = 1 (no load): value held, carry = 0, tick ignored.
- tick = 1, pause = 0, dir = 0 (count up):
  - ones < 9 and value < MAX: ones + 1;
  - ones = 9 and value < MAX: ones = 0, tens + 1;
  - value = MAX: value = MIN, carry = 1.
- tick = 1, pause = 0, dir = 1 (count down):
  - ones > 0 and value > MIN: ones − 1;
  - ones = 0 and value > MIN: ones = 9, tens − 1;
  - value = MIN: value = MAX, carry = 1.
- Latency and carry timing:
  - One cycle from tick to the updated value.
  - carry is registered and rises in the same cycle the wrapped value appears.
  - carry is low in all other cycles, including consecutive non-wrapping ticks.
- Digits stay valid BCD (0..9) and in [MIN_VAL, MAX_VAL] at all times after reset.
- Elaboration checks (abort on failure): MAX_VAL ≤ 99 and MIN_VAL < MAX_VAL.
- dir may change every cycle; there is no internal direction state.

Decomposition:
- Shared package clock_pkg:
  - typedef bcd_digit_t (4-bit);
  - constants SEC_MIN_MAX = 59, HOUR24_MAX = 23, HOUR12_MIN = 1, HOUR12_MAX = 12;
  - function to_bcd_pair (integer 0..99 → tens/ones).
- One sub-module: bcd_digit_counter.
  - A single-digit up/down counter with inc/dec/set inputs.
  - Outputs: at_nine and at_zero flags.
  - Instantiated twice (ones, tens).
- bcd_time_field_counter provides the range compare, wrap/preset logic, load validation and the carry/load_err registers.

Test Plan:
- Reset, defaults, up-count across the tens boundary: release reset → 00. Apply 60 ticks, dir = 0:
  - value reaches 09 → 10;
  - 59 → 00 with carry = 1 on exactly that cycle;
  - carry = 0 on the other 59 ticks.
- Down-count with MIN_VAL = 1, MAX_VAL = 12:
  - after reset the value is 01;
  - one tick with dir = 1 → 12 with carry = 1;
  - further ticks → 11, then 10, then 09, each with carry = 0.
- Load validation, MAX_VAL = 23:
  - load 2/3 → 23;
  - load 2/4 → stays 23, load_err = 1 for one cycle;
  - load 0/A (non-BCD ones digit) → stays 23, load_err = 1.
- Priority:
  - at value 45 with pause = 1, tick = 1 for 5 cycles → 45 held, carry = 0;
  - at 59, load 3/0 and tick in the same cycle → 30, carry = 0.
- Asynchronous reset mid-operation:
  - at 58, ticking, assert reset between clock edges → outputs 00 immediately, carry = 0;
  - after release the next tick gives 01.
- Cascade: two instances (seconds → minutes), seconds preset to 59, minutes to 59:
  - one tick → both read 00;
  - minutes carry pulses one cycle after the seconds carry.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared types and helpers for the BCD clock-field counters.
package clock_pkg;
  typedef logic [3:0] bcd_digit_t;

  typedef struct packed {
    bcd_digit_t tens;
    bcd_digit_t ones;
  } bcd_pair_t;

  localparam int SEC_MIN_MAX = 59;
  localparam int HOUR24_MAX  = 23;
  localparam int HOUR12_MIN  = 1;
  localparam int HOUR12_MAX  = 12;

  function automatic bcd_pair_t to_bcd_pair(input int value);
    bcd_pair_t p;
    p.tens = bcd_digit_t'(value / 10);
    p.ones = bcd_digit_t'(value % 10);
    return p;
  endfunction
endpackage

// File: rtl/bcd_time_field_counter_if.sv
// Control/status bundle of one time-field counter; master drives, slave counts.
interface bcd_time_field_counter_if;
  import clock_pkg::*;

  logic       tick;
  logic       pause;
  logic       dir;
  logic       load;
  bcd_digit_t load_tens;
  bcd_digit_t load_ones;
  bcd_digit_t tens;
  bcd_digit_t ones;
  logic       carry;
  logic       load_err;

  modport master (
    output tick, pause, dir, load, load_tens, load_ones,
    input  tens, ones, carry, load_err
  );

  modport slave (
    input  tick, pause, dir, load, load_tens, load_ones,
    output tens, ones, carry, load_err
  );
endinterface

// File: rtl/bcd_digit_counter.sv
// Single BCD digit with set/inc/dec; inc and dec roll over 9<->0 so the parent
// only has to decide when to step the next digit.
module bcd_digit_counter
  import clock_pkg::*;
#(
  parameter bcd_digit_t RST_VAL = '0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_inc,
  input  logic       i_dec,
  input  logic       i_set,
  input  bcd_digit_t i_set_val,
  output bcd_digit_t o_digit,
  output logic       o_at_nine,
  output logic       o_at_zero
);
  bcd_digit_t r_digit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_digit <= RST_VAL;
    end else if (i_set) begin
      r_digit <= i_set_val;
    end else if (i_inc) begin
      r_digit <= o_at_nine ? 4'd0 : r_digit + 4'd1;
    end else if (i_dec) begin
      r_digit <= o_at_zero ? 4'd9 : r_digit - 4'd1;
    end
  end

  assign o_digit   = r_digit;
  assign o_at_nine = (r_digit == 4'd9);
  assign o_at_zero = (r_digit == 4'd0);
endmodule

// File: rtl/bcd_time_field_counter.sv
// Two-digit BCD clock field with range wrap, up/down, checked preset and
// registered carry/borrow for chaining into the next field.
module bcd_time_field_counter
  import clock_pkg::*;
#(
  parameter int MIN_VAL = 0,
  parameter int MAX_VAL = SEC_MIN_MAX
) (
  input logic                      clk,
  input logic                      reset,
  bcd_time_field_counter_if.slave  bus
);
  localparam bcd_pair_t  MIN_BCD = to_bcd_pair(MIN_VAL);
  localparam bcd_pair_t  MAX_BCD = to_bcd_pair(MAX_VAL);
  localparam logic [7:0] MIN_V8  = 8'(MIN_VAL);
  localparam logic [7:0] MAX_V8  = 8'(MAX_VAL);

  if (MAX_VAL > 99 || MIN_VAL < 0 || MIN_VAL >= MAX_VAL) begin : g_param_check
    $fatal(1, "bcd_time_field_counter: need 0 <= MIN_VAL < MAX_VAL <= 99");
  end

  bcd_digit_t w_tens, w_ones;
  bcd_pair_t  w_cur, w_set_pair;
  logic       w_ones_nine, w_ones_zero;
  logic       w_unused_tens_nine, w_unused_tens_zero;
  logic [7:0] w_load_val;
  logic       w_load_ok, w_at_max, w_at_min;
  logic       w_step, w_wrap, w_set;
  logic       w_ones_inc, w_ones_dec, w_tens_inc, w_tens_dec;
  logic       r_carry, r_load_err;

  assign w_cur      = '{tens: w_tens, ones: w_ones};
  assign w_at_max   = (w_cur == MAX_BCD);
  assign w_at_min   = (w_cur == MIN_BCD);
  assign w_load_val = 8'(bus.load_tens) * 8'd10 + 8'(bus.load_ones);
  assign w_load_ok  = (bus.load_tens <= 4'd9) && (bus.load_ones <= 4'd9) &&
                      (w_load_val >= MIN_V8) && (w_load_val <= MAX_V8);

  // A load, valid or not, swallows any tick in the same cycle.
  assign w_step     = !bus.load && !bus.pause && bus.tick;
  assign w_wrap     = w_step && (bus.dir ? w_at_min : w_at_max);
  assign w_set      = (bus.load && w_load_ok) || w_wrap;
  assign w_set_pair = bus.load ? '{tens: bus.load_tens, ones: bus.load_ones}
                               : (bus.dir ? MAX_BCD : MIN_BCD);

  assign w_ones_inc = w_step && !bus.dir && !w_at_max;
  assign w_ones_dec = w_step &&  bus.dir && !w_at_min;
  assign w_tens_inc = w_ones_inc && w_ones_nine;
  assign w_tens_dec = w_ones_dec && w_ones_zero;

  bcd_digit_counter #(.RST_VAL(MIN_BCD.ones)) u_ones (
    .clk       (clk),
    .reset     (reset),
    .i_inc     (w_ones_inc),
    .i_dec     (w_ones_dec),
    .i_set     (w_set),
    .i_set_val (w_set_pair.ones),
    .o_digit   (w_ones),
    .o_at_nine (w_ones_nine),
    .o_at_zero (w_ones_zero)
  );

  bcd_digit_counter #(.RST_VAL(MIN_BCD.tens)) u_tens (
    .clk       (clk),
    .reset     (reset),
    .i_inc     (w_tens_inc),
    .i_dec     (w_tens_dec),
    .i_set     (w_set),
    .i_set_val (w_set_pair.tens),
    .o_digit   (w_tens),
    .o_at_nine (w_unused_tens_nine),
    .o_at_zero (w_unused_tens_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_carry    <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_carry    <= w_wrap;
      r_load_err <= bus.load && !w_load_ok;
    end
  end

  assign bus.tens     = w_tens;
  assign bus.ones     = w_ones;
  assign bus.carry    = r_carry;
  assign bus.load_err = r_load_err;
endmodule

// File: tb/tb_bcd_time_field_counter.sv
// Directed bench: seconds (00-59), hours-12 (01-12), hours-24 (00-23) fields
// plus a minutes field chained off the seconds carry.
module tb_bcd_time_field_counter;
  import clock_pkg::*;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  bcd_time_field_counter_if if_a ();
  bcd_time_field_counter_if if_b ();
  bcd_time_field_counter_if if_c ();
  bcd_time_field_counter_if if_m ();

  assign if_m.tick = if_a.carry;

  bcd_time_field_counter #(.MIN_VAL(0), .MAX_VAL(SEC_MIN_MAX)) dut_a (
    .clk(clk), .reset(reset), .bus(if_a));
  bcd_time_field_counter #(.MIN_VAL(HOUR12_MIN), .MAX_VAL(HOUR12_MAX)) dut_b (
    .clk(clk), .reset(reset), .bus(if_b));
  bcd_time_field_counter #(.MIN_VAL(0), .MAX_VAL(HOUR24_MAX)) dut_c (
    .clk(clk), .reset(reset), .bus(if_c));
  bcd_time_field_counter #(.MIN_VAL(0), .MAX_VAL(SEC_MIN_MAX)) dut_m (
    .clk(clk), .reset(reset), .bus(if_m));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         unit;
    logic       ld;
    logic       pa;
    logic       tk;
    logic       dr;
    logic [3:0] lt;
    logic [3:0] lo;
    logic [7:0] ev;
    logic       ec;
    logic       ee;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input int unit, input logic ld, input logic pa, input logic tk,
                       input logic dr, input logic [3:0] lt, input logic [3:0] lo);
    if_a.load = 0; if_a.pause = 0; if_a.tick = 0; if_a.dir = 0; if_a.load_tens = 0; if_a.load_ones = 0;
    if_b.load = 0; if_b.pause = 0; if_b.tick = 0; if_b.dir = 0; if_b.load_tens = 0; if_b.load_ones = 0;
    if_c.load = 0; if_c.pause = 0; if_c.tick = 0; if_c.dir = 0; if_c.load_tens = 0; if_c.load_ones = 0;
    if_m.load = 0; if_m.pause = 0; if_m.dir = 0; if_m.load_tens = 0; if_m.load_ones = 0;
    case (unit)
      0: begin if_a.load = ld; if_a.pause = pa; if_a.tick = tk; if_a.dir = dr; if_a.load_tens = lt; if_a.load_ones = lo; end
      1: begin if_b.load = ld; if_b.pause = pa; if_b.tick = tk; if_b.dir = dr; if_b.load_tens = lt; if_b.load_ones = lo; end
      2: begin if_c.load = ld; if_c.pause = pa; if_c.tick = tk; if_c.dir = dr; if_c.load_tens = lt; if_c.load_ones = lo; end
      default: begin if_m.load = ld; if_m.pause = pa; if_m.dir = dr; if_m.load_tens = lt; if_m.load_ones = lo; end
    endcase
  endtask

  function automatic logic [7:0] val(input int unit);
    case (unit)
      0: return {if_a.tens, if_a.ones};
      1: return {if_b.tens, if_b.ones};
      2: return {if_c.tens, if_c.ones};
      default: return {if_m.tens, if_m.ones};
    endcase
  endfunction

  function automatic logic [7:0] cry(input int unit);
    case (unit)
      0: return {7'd0, if_a.carry};
      1: return {7'd0, if_b.carry};
      2: return {7'd0, if_c.carry};
      default: return {7'd0, if_m.carry};
    endcase
  endfunction

  function automatic logic [7:0] err(input int unit);
    case (unit)
      0: return {7'd0, if_a.load_err};
      1: return {7'd0, if_b.load_err};
      2: return {7'd0, if_c.load_err};
      default: return {7'd0, if_m.load_err};
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] e;
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 4'd0, 4'd0);
    #12;
    check("rst_a_val", val(0), 8'h00);
    check("rst_b_val", val(1), 8'h01);
    check("rst_c_val", val(2), 8'h00);
    check("rst_a_carry", cry(0), 8'd0);
    check("rst_b_err", err(1), 8'd0);
    reset = 1'b1;
    step();
    check("post_rst_hold", val(0), 8'h00);

    // 60 up-ticks through 09->10 and 59->00
    for (int i = 1; i <= 60; i++) begin
      drive(0, 0, 0, 1, 0, 4'd0, 4'd0);
      step();
      e = 8'(((i % 60) / 10) * 16 + (i % 10));
      check($sformatf("up_val[%0d]", i), val(0), e);
      check($sformatf("up_carry[%0d]", i), cry(0), (i == 60) ? 8'd1 : 8'd0);
    end

    // hours-12 borrow and countdown
    drive(1, 0, 0, 1, 1, 4'd0, 4'd0);
    step();
    check("h12_borrow_val", val(1), 8'h12);
    check("h12_borrow_carry", cry(1), 8'd1);
    check("a_carry_dropped", cry(0), 8'd0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 1, 1, 4'd0, 4'd0);
      step();
      check($sformatf("h12_down_val[%0d]", i), val(1), (i == 0) ? 8'h11 : (i == 1) ? 8'h10 : 8'h09);
      check($sformatf("h12_down_carry[%0d]", i), cry(1), 8'd0);
    end

    // unit ld pa tk dr lt lo expected-value carry err
    tbl.push_back('{0, 1, 0, 0, 0, 4'd4, 4'd5, 8'h45, 0, 0});
    for (int i = 0; i < 5; i++) tbl.push_back('{0, 0, 1, 1, i % 2, 4'd0, 4'd0, 8'h45, 0, 0});
    tbl.push_back('{0, 1, 1, 0, 0, 4'd5, 4'd9, 8'h59, 0, 0});
    tbl.push_back('{0, 1, 0, 1, 0, 4'd3, 4'd0, 8'h30, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 1, 4'd0, 4'd0, 8'h29, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 0, 4'd0, 4'd0, 8'h30, 0, 0});
    tbl.push_back('{0, 1, 0, 0, 0, 4'd0, 4'd9, 8'h09, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 0, 4'd0, 4'd0, 8'h10, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 1, 4'd0, 4'd0, 8'h09, 0, 0});
    tbl.push_back('{0, 1, 0, 0, 0, 4'd0, 4'd0, 8'h00, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 1, 4'd0, 4'd0, 8'h59, 1, 0});
    tbl.push_back('{0, 0, 0, 1, 0, 4'd0, 4'd0, 8'h00, 1, 0});
    tbl.push_back('{0, 1, 0, 0, 0, 4'd6, 4'd0, 8'h00, 0, 1});
    tbl.push_back('{0, 0, 0, 0, 0, 4'd0, 4'd0, 8'h00, 0, 0});
    tbl.push_back('{0, 1, 0, 0, 0, 4'd0, 4'd10, 8'h00, 0, 1});
    tbl.push_back('{0, 1, 0, 0, 0, 4'd10, 4'd0, 8'h00, 0, 1});
    tbl.push_back('{2, 1, 0, 0, 0, 4'd2, 4'd3, 8'h23, 0, 0});
    tbl.push_back('{2, 1, 0, 0, 0, 4'd2, 4'd4, 8'h23, 0, 1});
    tbl.push_back('{2, 0, 0, 0, 0, 4'd0, 4'd0, 8'h23, 0, 0});
    tbl.push_back('{2, 1, 0, 0, 0, 4'd0, 4'd10, 8'h23, 0, 1});
    tbl.push_back('{2, 0, 0, 1, 0, 4'd0, 4'd0, 8'h00, 1, 0});
    tbl.push_back('{2, 0, 0, 1, 1, 4'd0, 4'd0, 8'h23, 1, 0});
    tbl.push_back('{2, 1, 0, 0, 0, 4'd1, 4'd9, 8'h19, 0, 0});
    tbl.push_back('{2, 0, 0, 1, 0, 4'd0, 4'd0, 8'h20, 0, 0});
    tbl.push_back('{1, 1, 0, 0, 0, 4'd1, 4'd2, 8'h12, 0, 0});
    tbl.push_back('{1, 1, 0, 0, 0, 4'd1, 4'd3, 8'h12, 0, 1});
    tbl.push_back('{1, 1, 0, 0, 0, 4'd0, 4'd0, 8'h12, 0, 1});
    tbl.push_back('{1, 0, 0, 1, 0, 4'd0, 4'd0, 8'h01, 1, 0});
    tbl.push_back('{1, 1, 0, 0, 0, 4'd0, 4'd9, 8'h09, 0, 0});
    tbl.push_back('{1, 0, 0, 1, 0, 4'd0, 4'd0, 8'h10, 0, 0});

    foreach (tbl[i]) begin
      drive(tbl[i].unit, tbl[i].ld, tbl[i].pa, tbl[i].tk, tbl[i].dr, tbl[i].lt, tbl[i].lo);
      step();
      check($sformatf("vec[%0d]_val", i), val(tbl[i].unit), tbl[i].ev);
      check($sformatf("vec[%0d]_carry", i), cry(tbl[i].unit), {7'd0, tbl[i].ec});
      check($sformatf("vec[%0d]_err", i), err(tbl[i].unit), {7'd0, tbl[i].ee});
    end

    // asynchronous reset between edges while ticking at 58/59
    drive(0, 1, 0, 0, 0, 4'd5, 4'd8);
    step();
    check("ar_load58", val(0), 8'h58);
    drive(0, 0, 0, 1, 0, 4'd0, 4'd0);
    step();
    check("ar_tick59", val(0), 8'h59);
    #3 reset = 1'b0;
    #1;
    check("ar_val_now", val(0), 8'h00);
    check("ar_carry_now", cry(0), 8'd0);
    #2 reset = 1'b1;
    drive(0, 1, 0, 0, 0, 4'd5, 4'd9);
    step();
    drive(0, 0, 0, 1, 0, 4'd0, 4'd0);
    step();
    check("ar_wrap_carry", cry(0), 8'd1);
    #3 reset = 1'b0;
    #1;
    check("ar_carry_cleared", cry(0), 8'd0);
    check("ar_b_reset", val(1), 8'h01);
    step();
    check("ar_held_in_reset", val(0), 8'h00);
    #3 reset = 1'b1;
    step();
    check("ar_next_tick", val(0), 8'h01);
    check("ar_next_carry", cry(0), 8'd0);

    // cascade: seconds carry -> minutes tick
    drive(0, 1, 0, 0, 0, 4'd5, 4'd9);
    if_m.load = 1; if_m.load_tens = 4'd5; if_m.load_ones = 4'd9;
    step();
    check("cas_sec_preset", val(0), 8'h59);
    check("cas_min_preset", val(3), 8'h59);
    drive(0, 0, 0, 1, 0, 4'd0, 4'd0);
    step();
    check("cas_sec_wrap", val(0), 8'h00);
    check("cas_sec_carry", cry(0), 8'd1);
    check("cas_min_wait", val(3), 8'h59);
    check("cas_min_carry_wait", cry(3), 8'd0);
    drive(0, 0, 0, 0, 0, 4'd0, 4'd0);
    step();
    check("cas_min_wrap", val(3), 8'h00);
    check("cas_min_carry", cry(3), 8'd1);
    check("cas_sec_carry_low", cry(0), 8'd0);
    step();
    check("cas_min_carry_low", cry(3), 8'd0);
    check("cas_sec_hold", val(0), 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
